// File: rtl/risc_control_unit_if.sv
// Control bundle between the sequencer and the 8-bit datapath; no handshake, no backpressure.
// master = control unit (drives load/select strobes), slave = datapath (drives IR contents and Zflag).
interface risc_control_unit_if #(
  parameter int word_size  = 8,
  parameter int state_size = 4,
  parameter int Sel1_size  = 3,
  parameter int Sel2_size  = 2
);
  logic [word_size-1:0]  instruction;
  logic                  Zflag;
  logic                  Load_R0, Load_R1, Load_R2, Load_R3;
  logic                  Load_PC, Inc_PC;
  logic [Sel1_size-1:0]  Sel_Bus_1_Mux;
  logic [Sel2_size-1:0]  Sel_Bus_2_Mux;
  logic                  Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
  logic                  write;
  logic                  halted;
  logic [state_size-1:0] state;

  modport master (
    input  instruction, Zflag,
    output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
           Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
           Load_Reg_Y, Load_Reg_Z, write, halted, state
  );

  modport slave (
    output instruction, Zflag,
    input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
           Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
           Load_Reg_Y, Load_Reg_Z, write, halted, state
  );
endinterface

// File: rtl/risc_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit unit; 3-5 clocks per instruction, halts on illegal opcode.
// No backpressure: every output is a combinational decode of the current state and IR contents.
module risc_control_unit #(
  parameter int word_size  = 8,
  parameter int op_size    = 4,
  parameter int state_size = 4,
  parameter int Sel1_size  = 3,
  parameter int Sel2_size  = 2
) (
  input logic               clk,
  input logic               rst,
  risc_control_unit_if.master cu
);

  typedef enum logic [state_size-1:0] {
    S_idle = 4'd0, S_fet1 = 4'd1, S_fet2 = 4'd2, S_dec  = 4'd3,
    S_ex1  = 4'd4, S_rd1  = 4'd5, S_rd2  = 4'd6, S_wr1  = 4'd7,
    S_wr2  = 4'd8, S_br1  = 4'd9, S_br2  = 4'd10, S_halt = 4'd11
  } state_t;

  localparam logic [op_size-1:0] OP_NOP = op_size'(0);
  localparam logic [op_size-1:0] OP_ADD = op_size'(1);
  localparam logic [op_size-1:0] OP_SUB = op_size'(2);
  localparam logic [op_size-1:0] OP_AND = op_size'(3);
  localparam logic [op_size-1:0] OP_NOT = op_size'(4);
  localparam logic [op_size-1:0] OP_RD  = op_size'(5);
  localparam logic [op_size-1:0] OP_WR  = op_size'(6);
  localparam logic [op_size-1:0] OP_BR  = op_size'(7);
  localparam logic [op_size-1:0] OP_BRZ = op_size'(8);

  localparam logic [Sel1_size-1:0] SEL1_PC  = Sel1_size'(4);
  localparam logic [Sel2_size-1:0] SEL2_ALU = Sel2_size'(0);
  localparam logic [Sel2_size-1:0] SEL2_B1  = Sel2_size'(1);
  localparam logic [Sel2_size-1:0] SEL2_MEM = Sel2_size'(2);

  state_t             state_q, state_d;
  logic [op_size-1:0] opcode;
  logic [1:0]         src, dest;

  logic [3:0]           load_r;
  logic                 load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, wr, halt;
  logic [Sel1_size-1:0] sel1;
  logic [Sel2_size-1:0] sel2;

  assign opcode = cu.instruction[word_size-1 -: op_size];
  assign src    = cu.instruction[3:2];
  assign dest   = cu.instruction[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_idle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_halt;
    case (state_q)
      S_idle: state_d = S_fet1;
      S_fet1: state_d = S_fet2;
      S_fet2: state_d = S_dec;
      S_dec: begin
        case (opcode)
          OP_NOP, OP_NOT:         state_d = S_fet1;
          OP_ADD, OP_SUB, OP_AND: state_d = S_ex1;
          OP_RD:                  state_d = S_rd1;
          OP_WR:                  state_d = S_wr1;
          OP_BR:                  state_d = S_br1;
          OP_BRZ:                 state_d = cu.Zflag ? S_br1 : S_fet1;
          default:                state_d = S_halt;
        endcase
      end
      S_ex1:  state_d = S_fet1;
      S_rd1:  state_d = S_rd2;
      S_rd2:  state_d = S_fet1;
      S_wr1:  state_d = S_wr2;
      S_wr2:  state_d = S_fet1;
      S_br1:  state_d = S_br2;
      S_br2:  state_d = S_fet1;
      default: state_d = S_halt;
    endcase
  end

  always_comb begin
    load_r     = '0;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    wr         = 1'b0;
    halt       = 1'b0;
    sel1       = '0;
    sel2       = '0;
    case (state_q)
      S_fet1: begin
        sel1 = SEL1_PC; sel2 = SEL2_B1; load_add_r = 1'b1; inc_pc = 1'b1;
      end
      S_fet2: begin
        sel2 = SEL2_MEM; load_ir = 1'b1;
      end
      S_dec: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            sel1 = Sel1_size'(src); sel2 = SEL2_B1; load_reg_y = 1'b1;
          end
          OP_NOT: begin
            sel1 = Sel1_size'(src); sel2 = SEL2_ALU; load_reg_z = 1'b1; load_r[dest] = 1'b1;
          end
          OP_RD, OP_WR: begin
            sel1 = SEL1_PC; sel2 = SEL2_B1; load_add_r = 1'b1; inc_pc = 1'b1;
          end
          OP_BR: begin
            sel1 = SEL1_PC; sel2 = SEL2_B1; load_add_r = 1'b1;
          end
          OP_BRZ: begin
            // Not taken: step PC past the branch-target byte.
            if (cu.Zflag) begin
              sel1 = SEL1_PC; sel2 = SEL2_B1; load_add_r = 1'b1;
            end else begin
              inc_pc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_ex1: begin
        sel1 = Sel1_size'(dest); sel2 = SEL2_ALU; load_reg_z = 1'b1; load_r[dest] = 1'b1;
      end
      S_rd1, S_wr1, S_br1: begin
        sel2 = SEL2_MEM; load_add_r = 1'b1;
      end
      S_rd2: begin
        sel2 = SEL2_MEM; load_r[dest] = 1'b1;
      end
      S_wr2: begin
        sel1 = Sel1_size'(src); wr = 1'b1;
      end
      S_br2: begin
        sel2 = SEL2_MEM; load_pc = 1'b1;
      end
      S_halt: halt = 1'b1;
      default: ;
    endcase
  end

  assign cu.Load_R0       = load_r[0];
  assign cu.Load_R1       = load_r[1];
  assign cu.Load_R2       = load_r[2];
  assign cu.Load_R3       = load_r[3];
  assign cu.Load_PC       = load_pc;
  assign cu.Inc_PC        = inc_pc;
  assign cu.Sel_Bus_1_Mux = sel1;
  assign cu.Sel_Bus_2_Mux = sel2;
  assign cu.Load_IR       = load_ir;
  assign cu.Load_Add_R    = load_add_r;
  assign cu.Load_Reg_Y    = load_reg_y;
  assign cu.Load_Reg_Z    = load_reg_z;
  assign cu.write         = wr;
  assign cu.halted        = halt;
  assign cu.state         = state_q;

endmodule

// File: tb/tb_risc_control_unit.sv
// Scoreboard bench for risc_control_unit: each instruction pushes its per-cycle expected
// control vectors, which are popped and compared one per clock on the falling edge.
module tb_risc_control_unit;

  localparam logic [3:0] S_IDLE = 4'd0, S_FET1 = 4'd1, S_FET2 = 4'd2, S_DEC = 4'd3,
                         S_EX1 = 4'd4, S_RD1 = 4'd5, S_RD2 = 4'd6, S_WR1 = 4'd7,
                         S_WR2 = 4'd8, S_BR1 = 4'd9, S_BR2 = 4'd10, S_HALT = 4'd11;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] ld_r;
    logic       ld_pc, inc_pc;
    logic [2:0] sel1;
    logic [1:0] sel2;
    logic       ld_ir, ld_ar, ld_y, ld_z, wr, hlt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  risc_control_unit_if bus();

  risc_control_unit dut (.clk(clk), .rst(rst), .cu(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t blank(input logic [3:0] st);
    exp_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic exp_t obs();
    exp_t r;
    r.st     = bus.state;
    r.ld_r   = {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0};
    r.ld_pc  = bus.Load_PC;
    r.inc_pc = bus.Inc_PC;
    r.sel1   = bus.Sel_Bus_1_Mux;
    r.sel2   = bus.Sel_Bus_2_Mux;
    r.ld_ir  = bus.Load_IR;
    r.ld_ar  = bus.Load_Add_R;
    r.ld_y   = bus.Load_Reg_Y;
    r.ld_z   = bus.Load_Reg_Z;
    r.wr     = bus.write;
    r.hlt    = bus.halted;
    return r;
  endfunction

  // Expected cycle-by-cycle control vectors for one instruction starting in fetch 1.
  task automatic push_instr(input logic [7:0] ins, input logic z);
    exp_t r;
    logic [1:0] src, dst;
    src = ins[3:2];
    dst = ins[1:0];
    r = blank(S_FET1); r.sel1 = 3'd4; r.sel2 = 2'd1; r.ld_ar = 1'b1; r.inc_pc = 1'b1; sb.push_back(r);
    r = blank(S_FET2); r.sel2 = 2'd2; r.ld_ir = 1'b1; sb.push_back(r);
    case (ins[7:4])
      4'd0: sb.push_back(blank(S_DEC));
      4'd1, 4'd2, 4'd3: begin
        r = blank(S_DEC); r.sel1 = {1'b0, src}; r.sel2 = 2'd1; r.ld_y = 1'b1; sb.push_back(r);
        r = blank(S_EX1); r.sel1 = {1'b0, dst}; r.ld_z = 1'b1; r.ld_r[dst] = 1'b1; sb.push_back(r);
      end
      4'd4: begin
        r = blank(S_DEC); r.sel1 = {1'b0, src}; r.ld_z = 1'b1; r.ld_r[dst] = 1'b1; sb.push_back(r);
      end
      4'd5: begin
        r = blank(S_DEC); r.sel1 = 3'd4; r.sel2 = 2'd1; r.ld_ar = 1'b1; r.inc_pc = 1'b1; sb.push_back(r);
        r = blank(S_RD1); r.sel2 = 2'd2; r.ld_ar = 1'b1; sb.push_back(r);
        r = blank(S_RD2); r.sel2 = 2'd2; r.ld_r[dst] = 1'b1; sb.push_back(r);
      end
      4'd6: begin
        r = blank(S_DEC); r.sel1 = 3'd4; r.sel2 = 2'd1; r.ld_ar = 1'b1; r.inc_pc = 1'b1; sb.push_back(r);
        r = blank(S_WR1); r.sel2 = 2'd2; r.ld_ar = 1'b1; sb.push_back(r);
        r = blank(S_WR2); r.sel1 = {1'b0, src}; r.wr = 1'b1; sb.push_back(r);
      end
      4'd7, 4'd8: begin
        if (ins[7:4] == 4'd8 && !z) begin
          r = blank(S_DEC); r.inc_pc = 1'b1; sb.push_back(r);
        end else begin
          r = blank(S_DEC); r.sel1 = 3'd4; r.sel2 = 2'd1; r.ld_ar = 1'b1; sb.push_back(r);
          r = blank(S_BR1); r.sel2 = 2'd2; r.ld_ar = 1'b1; sb.push_back(r);
          r = blank(S_BR2); r.sel2 = 2'd2; r.ld_pc = 1'b1; sb.push_back(r);
        end
      end
      default: begin
        sb.push_back(blank(S_DEC));
        r = blank(S_HALT); r.hlt = 1'b1;
        repeat (10) sb.push_back(r);
      end
    endcase
  endtask

  task automatic drain(input string tag);
    exp_t r, o;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      o = obs();
      chk(tag, 32'(o), 32'(r));
      chk({tag, "_pc_excl"}, 32'(o.ld_pc & o.inc_pc), 32'd0);
      chk({tag, "_reg_onehot"}, 32'($countones(o.ld_r) > 1), 32'd0);
      chk({tag, "_wr_only_wr2"}, 32'(o.wr && (o.st != S_WR2)), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [7:0] ins, input logic z, input string tag);
    bus.instruction = ins;
    bus.Zflag       = z;
    push_instr(ins, z);
    drain(tag);
  endtask

  task automatic release_reset();
    rst = 1'b1;
    sb.push_back(blank(S_IDLE));
    drain("reset_release");
  endtask

  initial begin
    logic [7:0] ins;
    rst = 1'b0;
    bus.instruction = 8'h00;
    bus.Zflag = 1'b0;
    repeat (3) @(negedge clk);
    sb.push_back(blank(S_IDLE));
    drain("reset_hold");
    release_reset();

    run(8'h1B, 1'b0, "add_r2_r3");
    run(8'h51, 1'b0, "rd_r1");
    run(8'h68, 1'b1, "wr_r2");
    run(8'h80, 1'b0, "brz_not_taken");
    run(8'h80, 1'b1, "brz_taken");
    run(8'h2E, 1'b1, "sub_r3_r2");
    run(8'h30, 1'b0, "and_r0_r0");
    run(8'h47, 1'b1, "not_r1_r3");
    run(8'h0F, 1'b0, "nop");
    run(8'h75, 1'b0, "br");
    run(8'h83, 1'b1, "brz_taken_bits");

    for (int i = 0; i < 150; i++) begin
      ins = {4'($urandom_range(0, 8)), 4'($urandom)};
      run(ins, 1'($urandom), "random");
    end

    run(8'hF0, 1'b0, "illegal_halt");
    rst = 1'b0;
    #1;
    chk("async_rst_from_halt", 32'(bus.state), 32'(S_IDLE));
    @(negedge clk);
    release_reset();

    bus.instruction = 8'h1B;
    bus.Zflag = 1'b0;
    push_instr(8'h1B, 1'b0);
    void'(sb.pop_back());
    drain("add_to_ex1");
    chk("reached_ex1", 32'(bus.state), 32'(S_EX1));
    rst = 1'b0;
    #1;
    chk("async_rst_mid_ex1", 32'(bus.state), 32'(S_IDLE));
    chk("rst_outputs_zero", 32'(obs()), 32'(blank(S_IDLE)));
    @(negedge clk);
    release_reset();
    run(8'h9C, 1'b0, "illegal_9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
